// File: rtl/deshifter8.sv
// Serial-to-parallel receiver: frames WIDTH bits behind a start marker and
// offers the completed word on a valid/ready handshake, flagging dropped bits.
module deshifter8 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_in,
  input  logic                     s_valid,
  input  logic                     s_start,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     overrun
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   ONE  = CW'(1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FULL
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] sr_cap;

  // Shift register contents after capturing s_in; a start bit begins from zero.
  always_comb begin
    sr_cap = '0;
    if (!s_start) begin
      sr_cap = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
    if (MSB_FIRST) begin
      sr_cap[0] = s_in;
    end else begin
      sr_cap[WIDTH-1] = s_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid && s_start) begin
          sr_d    = sr_cap;
          cnt_d   = ONE;
          state_d = RECV;
        end
      end
      RECV: begin
        if (s_valid) begin
          sr_d = sr_cap;
          if (s_start) begin
            cnt_d = ONE;
          end else if (cnt_q == LAST) begin
            dout_d  = sr_cap;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      FULL: begin
        // A start bit arriving on the handshake edge opens the next frame at once.
        if (d_ready) begin
          if (s_valid && s_start) begin
            sr_d    = sr_cap;
            cnt_d   = ONE;
            state_d = RECV;
          end else begin
            state_d = IDLE;
          end
        end else if (s_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_out   = dout_q;
    d_valid = (state_q == FULL);
    busy    = (state_q == RECV);
    cnt     = cnt_q;
    overrun = ovr_q;
  end

endmodule

// File: tb/tb_deshifter8.sv
// Bench for deshifter8: three configurations driven in parallel and compared
// every cycle against a bit-list model of the framing rules.
module tb_deshifter8;

  localparam int WA [3] = '{8, 8, 2};
  localparam bit MA [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s_in = 1'b0, s_valid = 1'b0, s_start = 1'b0, d_ready = 1'b0;

  logic [7:0] do0, do1;
  logic [1:0] do2;
  logic [2:0] c0, c1;
  logic [0:0] c2;
  logic [2:0] dv, bz, ov;

  int vectors = 0;
  int miscompares = 0;

  deshifter8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .d_out(do0), .d_valid(dv[0]), .d_ready(d_ready), .busy(bz[0]), .cnt(c0), .overrun(ov[0]));
  deshifter8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .d_out(do1), .d_valid(dv[1]), .d_ready(d_ready), .busy(bz[1]), .cnt(c1), .overrun(ov[1]));
  deshifter8 #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .d_out(do2), .d_valid(dv[2]), .d_ready(d_ready), .busy(bz[2]), .cnt(c2), .overrun(ov[2]));

  always #5 clk = ~clk;

  // Model: the bits of the frame in arrival order, plus a held word.
  bit          fb   [3][32];
  int unsigned n    [3] = '{0, 0, 0};
  bit          full [3] = '{0, 0, 0};
  logic [31:0] word [3] = '{0, 0, 0};
  bit          ovr  [3] = '{0, 0, 0};

  function automatic logic [31:0] assemble(input int k);
    logic [31:0] w = '0;
    for (int i = 0; i < WA[k]; i++)
      if (fb[k][i]) w |= MA[k] ? (32'd1 << (WA[k] - 1 - i)) : (32'd1 << i);
    return w;
  endfunction

  task automatic capture(input int k, input bit start, input bit b);
    if (start) n[k] = 0;
    fb[k][n[k]] = b;
    n[k]++;
    if (n[k] == WA[k]) begin
      word[k] = assemble(k);
      full[k] = 1'b1;
      n[k]    = 0;
    end
  endtask

  task automatic step(input int k);
    ovr[k] = 1'b0;
    if (full[k]) begin
      if (d_ready) begin
        full[k] = 1'b0;
        if (s_valid && s_start) capture(k, 1'b1, s_in);
      end else if (s_valid) begin
        ovr[k] = 1'b1;
      end
    end else if (s_valid && (s_start || n[k] != 0)) begin
      capture(k, s_start, s_in);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        n[k] = 0; full[k] = 1'b0; word[k] = '0; ovr[k] = 1'b0;
      end else begin
        step(k);
      end
    end
  end

  function automatic logic [31:0] act_dout(input int k);
    case (k)
      0:       return 32'(do0);
      1:       return 32'(do1);
      default: return 32'(do2);
    endcase
  endfunction

  function automatic logic [31:0] act_cnt(input int k);
    case (k)
      0:       return 32'(c0);
      1:       return 32'(c1);
      default: return 32'(c2);
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[u%0d] @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("d_out",   k, act_dout(k), word[k]);
      chk("d_valid", k, 32'(dv[k]), 32'(full[k]));
      chk("busy",    k, 32'(bz[k]), 32'(!full[k] && n[k] != 0));
      chk("cnt",     k, act_cnt(k), n[k]);
      chk("overrun", k, 32'(ov[k]), 32'(ovr[k]));
    end
  endtask

  task automatic cyc(input bit v, input bit st, input bit b, input bit rdy);
    @(negedge clk);
    check_all();
    s_valid = v; s_start = st; s_in = b; d_ready = rdy;
  endtask

  task automatic send_byte(input logic [7:0] val, input bit rdy);
    for (int i = 7; i >= 0; i--) cyc(1'b1, i == 7, val[i], rdy);
  endtask

  initial begin
    logic [7:0] pat;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_dvalid", 0, 32'(dv), 32'd0);
    chk("rst_cnt",    0, act_cnt(0), 32'd0);

    // 0,1,0,1,1,1,0,0 with d_ready high
    pat = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i == 0, pat[7-i], 1'b1);
      if (i >= 1) begin
        chk("cnt_step", 0, act_cnt(0), 32'(i));
        chk("busy_step", 0, 32'(bz[0]), 32'd1);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_5C",    0, act_dout(0), 32'h5C);
    chk("lit_3A",    1, act_dout(1), 32'h3A);
    chk("model_5C",  0, word[0], 32'h5C);
    chk("model_3A",  1, word[1], 32'h3A);
    chk("dv_5C",     0, 32'(dv[0]), 32'd1);
    chk("cnt_done",  0, act_cnt(0), 32'd0);
    chk("busy_done", 0, 32'(bz[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dv_drop",   0, 32'(dv[0]), 32'd0);

    // Backpressure
    send_byte(8'hCD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_dout", 0, act_dout(0), 32'hCD);
      chk("bp_dv",   0, 32'(dv[0]), 32'd1);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr1", 0, 32'(ov[0]), 32'd1);
    chk("bp_hold", 0, act_dout(0), 32'hCD);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_ovr0", 0, 32'(ov[0]), 32'd0);
    chk("bp_dv2",  0, 32'(dv[0]), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_idle", 0, 32'(dv[0]), 32'd0);

    // Resync
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    send_byte(8'h19, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rs_dout", 0, act_dout(0), 32'h19);
    chk("rs_dv",   0, 32'(dv[0]), 32'd1);
    chk("rs_ovr",  0, 32'(ov[0]), 32'd0);

    // Back-to-back: start of 0xDC lands on the 0x5C handshake edge
    send_byte(8'h5C, 1'b0);
    send_byte(8'hDC, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_dout", 0, act_dout(0), 32'hDC);
    chk("b2b_dv",   0, 32'(dv[0]), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_dout", 0, act_dout(0), 32'd0);
    chk("ar_cnt",  0, act_cnt(0), 32'd0);
    chk("ar_busy", 0, 32'(bz), 32'd0);
    chk("ar_dv",   0, 32'(dv), 32'd0);
    chk("ar_ovr",  0, 32'(ov), 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    send_byte(8'hA5, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_A5", 0, act_dout(0), 32'hA5);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #3 reset_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
